// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the four-master bus arbiter: channel count, owner encodings,
// active-low signalling levels and the grant decode helper.
// Pure declarations; no logic, no latency, no flow control.
package bus_arbiter_pkg;

    localparam int BUS_MASTER_CH = 4;
    localparam int BUS_OWNER_W   = 2;
    localparam int HOLD_DEFAULT  = 16;

    // Request/grant lines are active-low throughout the bus.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // State encoding doubles as the owner index / master mux select.
    typedef enum logic [BUS_OWNER_W-1:0] {
        OWN_M0 = 2'd0,
        OWN_M1 = 2'd1,
        OWN_M2 = 2'd2,
        OWN_M3 = 2'd3
    } owner_e;

    // One-hot-low grant vector for a given owner: exactly one bit low.
    function automatic logic [BUS_MASTER_CH-1:0] grant_decode(input logic [BUS_OWNER_W-1:0] own);
        grant_decode = ~(4'b0001 << own);
    endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Round-robin next-owner pick: scans owner+1, +2, +3 (mod 4) for the first active-low request.
// Purely combinational, zero latency; no flow control.
// Ports: owner_i current owner, req_n_i active-low requests [m3..m0], next_o picked index, found_o hit flag.
module bus_rr_pick
    import bus_arbiter_pkg::*;
(
    input  logic [BUS_OWNER_W-1:0]   owner_i,
    input  logic [BUS_MASTER_CH-1:0] req_n_i,
    output logic [BUS_OWNER_W-1:0]   next_o,
    output logic                     found_o
);

    logic [BUS_OWNER_W-1:0] cand;

    always_comb begin
        next_o  = owner_i;
        found_o = 1'b0;
        cand    = owner_i;
        // The current owner itself is never a candidate, so a releasing
        // master can never be handed the bus straight back.
        for (int k = 1; k < BUS_MASTER_CH; k++) begin
            cand = owner_i + BUS_OWNER_W'(k);
            if (!found_o && (req_n_i[cand] == ENABLE_)) begin
                next_o  = cand;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Four-master bus arbiter: active-low req/grant, round-robin priority, per-tenure hold limit.
// Latency: request to idle bus or handover after release is granted on the next rising edge.
// Backpressure: a requester waits with req_ low until granted; owner is preempted after HOLD_MAX contended cycles.
// Ports: clk, reset (async active-low), m0..m3_req_ (active-low requests), m0..m3_grnt_ (active-low
//        registered grants, one-hot-low), owner (registered owner index), busy (owner currently requesting).
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_DEFAULT,
    parameter int HOLD_W   = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   m0_req_,
    input  logic                   m1_req_,
    input  logic                   m2_req_,
    input  logic                   m3_req_,
    output logic                   m0_grnt_,
    output logic                   m1_grnt_,
    output logic                   m2_grnt_,
    output logic                   m3_grnt_,
    output logic [BUS_OWNER_W-1:0] owner,
    output logic                   busy
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

    logic [BUS_MASTER_CH-1:0] req_n;
    logic [BUS_MASTER_CH-1:0] grnt_n;
    owner_e                   state_q, state_d;
    logic [HOLD_W-1:0]        hold_q, hold_d;
    logic                     owner_req;
    logic                     others_req;
    logic [BUS_OWNER_W-1:0]   pick_idx;
    logic                     pick_found;

    assign req_n = {m3_req_, m2_req_, m1_req_, m0_req_};

    assign owner_req  = (req_n[state_q] == ENABLE_);
    // grnt_n is high on every non-owner lane, so it masks the owner out.
    assign others_req = |(~req_n & grnt_n);

    bus_rr_pick u_pick (
        .owner_i (state_q),
        .req_n_i (req_n),
        .next_o  (pick_idx),
        .found_o (pick_found)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= OWN_M0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;

        if (!owner_req) begin
            // Owner released: hand over if anyone else wants it, else stay parked.
            if (pick_found) begin
                state_d = owner_e'(pick_idx);
            end
        end else if ((hold_q == HOLD_LAST) && pick_found) begin
            // Tenure limit reached under contention: forced handover.
            state_d = owner_e'(pick_idx);
        end

        if ((state_d != state_q) || !others_req) begin
            hold_d = '0;
        end else if (owner_req && (hold_q != HOLD_LAST)) begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    // Grants come straight off the owner register, so they inherit its
    // async reset and can never glitch to two-low during a handover.
    assign grnt_n   = grant_decode(state_q);
    assign m0_grnt_ = grnt_n[0];
    assign m1_grnt_ = grnt_n[1];
    assign m2_grnt_ = grnt_n[2];
    assign m3_grnt_ = grnt_n[3];

    assign owner = state_q;
    assign busy  = owner_req;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req_n;
    logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
    logic [1:0] owner;
    logic       busy;
    logic [3:0] grnt;
    logic       done;

    int checks;
    int errors;

    typedef struct {
        logic [3:0] req_n;
        logic [1:0] owner;
        logic [3:0] grnt_n;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    assign grnt = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};

    bus_arbiter #(.HOLD_MAX(16), .HOLD_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req_  (req_n[0]),
        .m1_req_  (req_n[1]),
        .m2_req_  (req_n[2]),
        .m3_req_  (req_n[3]),
        .m0_grnt_ (m0_grnt_),
        .m1_grnt_ (m1_grnt_),
        .m2_grnt_ (m2_grnt_),
        .m3_grnt_ (m3_grnt_),
        .owner    (owner),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: exactly one grant low, and it belongs to the reported owner.
    always @(negedge clk) begin
        if (!done) begin
            logic [3:0] inv;
            logic [3:0] exp_g;
            inv = ~grnt;
            exp_g = 4'b0001 << owner;
            check("onehot_low", 8'($countones(inv)), 8'd1);
            check("grant_matches_owner", {4'h0, inv}, {4'h0, exp_g});
        end
    end

    task automatic add(input logic [3:0] r, input logic [1:0] o, input logic [3:0] g, input logic b);
        vec_t v;
        v.req_n = r; v.owner = o; v.grnt_n = g; v.busy = b;
        vecs.push_back(v);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        done   = 1'b0;
        reset  = 1'b0;
        req_n  = 4'b1111;

        // Reset values, before any clock edge.
        #2;
        check("rst_owner", {6'd0, owner}, 8'd0);
        check("rst_grnt", {4'h0, grnt}, 8'h0E);
        check("rst_busy", {7'd0, busy}, 8'd0);

        // Vector table: {req_n[m3..m0], expected owner, grants, busy} after each edge.
        for (int i = 0; i < 5; i++) add(4'b1111, 2'd0, 4'b1110, 1'b0); // idle, parked on m0
        add(4'b1011, 2'd2, 4'b1011, 1'b1);  // m2 request from idle
        add(4'b1111, 2'd2, 4'b1011, 1'b0);  // m2 releases, parks on m2
        add(4'b1110, 2'd0, 4'b1110, 1'b1);  // m0 requests, scan 3 then 0
        add(4'b1111, 2'd0, 4'b1110, 1'b0);  // park on m0
        add(4'b0101, 2'd1, 4'b1101, 1'b1);  // m1 and m3 together -> m1
        add(4'b0111, 2'd3, 4'b0111, 1'b1);  // m1 releases -> m3
        add(4'b1110, 2'd0, 4'b1110, 1'b1);  // m3 releases, m0 requests -> wrap 3->0
        add(4'b0000, 2'd0, 4'b1110, 1'b1);  // everyone requests, owner keeps it
        add(4'b0001, 2'd1, 4'b1101, 1'b1);  // m0 releases -> m1, never back to m0
        add(4'b1111, 2'd1, 4'b1101, 1'b0);  // park on m1

        @(negedge clk);
        reset = 1'b1;
        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk);
            req_n = vecs[i].req_n;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_owner", i), {6'd0, owner}, {6'd0, vecs[i].owner});
            check($sformatf("vec%0d_grnt", i), {4'h0, grnt}, {4'h0, vecs[i].grnt_n});
            check($sformatf("vec%0d_busy", i), {7'd0, busy}, {7'd0, vecs[i].busy});
        end

        // Hold limit: m0 owns, m1 requests at t0; m0 keeps 16 edges, then m1.
        @(negedge clk);
        req_n = 4'b1110;
        @(posedge clk); #1;
        check("hold_setup_owner", {6'd0, owner}, 8'd0);
        @(negedge clk);
        req_n = 4'b1100;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold_edge%0d_owner", i + 1), {6'd0, owner}, (i < 15) ? 8'd0 : 8'd1);
        end
        // m0 still requesting but must wait for m1 to release.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_wait_owner", {6'd0, owner}, 8'd1);
        end
        @(negedge clk);
        req_n = 4'b1110;
        @(posedge clk); #1;
        check("hold_return_owner", {6'd0, owner}, 8'd0);

        // Reset mid-tenure takes effect without a clock edge.
        @(negedge clk);
        req_n = 4'b1011;
        @(posedge clk); #1;
        check("pre_rst_owner", {6'd0, owner}, 8'd2);
        check("pre_rst_busy", {7'd0, busy}, 8'd1);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_owner", {6'd0, owner}, 8'd0);
        check("midrst_grnt", {4'h0, grnt}, 8'h0E);
        check("midrst_busy", {7'd0, busy}, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_owner", {6'd0, owner}, 8'd2);

        // Sub-cycle request glitch between edges is ignored.
        @(negedge clk);
        req_n = 4'b1111;
        @(posedge clk); #1;
        check("park2_busy", {7'd0, busy}, 8'd0);
        #2 req_n = 4'b1101;
        #2 req_n = 4'b1111;
        @(posedge clk); #1;
        check("glitch_owner", {6'd0, owner}, 8'd2);
        check("glitch_grnt", {4'h0, grnt}, 8'h0B);

        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
